// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared
//               combinational ALU. Each granted operation is registered into
//               an issue stage (S1) that drives the ALU. The ALU result is
//               then registered into a response stage (S2) and returned to
//               the requester with a one-cycle strobe. Saturating per-requester
//               grant counters are also provided.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_ctl,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_ctl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,

    input  logic             flush,

    output logic [6:0]       alu_ctl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_branch_enable,

    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [31:0]      resp_out,
    output logic             resp_branch,

    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Priority state: 1 means requester 1 won the last transfer, so
    // requester 0 wins the next contention.
    logic             r_last_grant;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic [6:0]       w_sel_ctl;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;

    // Issue stage (S1)
    logic             r_s1_valid;
    logic             r_s1_id;
    logic [6:0]       r_s1_ctl;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;

    // Response stage (S2)
    logic             r_s2_valid;
    logic             r_s2_id;
    logic [31:0]      r_s2_out;
    logic             r_s2_branch;

    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Grant selection: a lone requester always wins; on contention the one
    // not granted last wins. Nothing is granted during reset or flush.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset && !flush) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_xfer0    = req0_valid & w_grant0;
    assign w_xfer1    = req1_valid & w_grant1;
    assign w_xfer     = w_xfer0 | w_xfer1;

    assign w_sel_ctl  = w_xfer1 ? req1_ctl : req0_ctl;
    assign w_sel_a    = w_xfer1 ? req1_a   : req0_a;
    assign w_sel_b    = w_xfer1 ? req1_b   : req0_b;

    // Round-robin pointer follows actual transfers only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_xfer1;
        end
    end

    // Issue stage: capture the granted operation; flush squashes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_ctl   <= 7'd0;
            r_s1_a     <= 32'd0;
            r_s1_b     <= 32'd0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_id  <= w_xfer1;
                r_s1_ctl <= w_sel_ctl;
                r_s1_a   <= w_sel_a;
                r_s1_b   <= w_sel_b;
            end
        end
    end

    // The ALU sees zeros whenever no operation is issued.
    assign alu_ctl = r_s1_valid ? r_s1_ctl : 7'd0;
    assign alu_a   = r_s1_valid ? r_s1_a   : 32'd0;
    assign alu_b   = r_s1_valid ? r_s1_b   : 32'd0;

    // Response stage: register the ALU result; data holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_id     <= 1'b0;
            r_s2_out    <= 32'd0;
            r_s2_branch <= 1'b0;
        end else if (flush) begin
            r_s2_valid  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_id     <= r_s1_id;
                r_s2_out    <= alu_out;
                r_s2_branch <= alu_branch_enable;
            end
        end
    end

    assign resp0_valid = r_s2_valid & !r_s2_id;
    assign resp1_valid = r_s2_valid &  r_s2_id;
    assign resp_out    = r_s2_out;
    assign resp_branch = r_s2_branch;

    // Saturating accepted-operation counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_xfer0 && (r_cnt0 != c_CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + c_CNT_ONE;
            end
            if (w_xfer1 && (r_cnt1 != c_CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + c_CNT_ONE;
            end
        end
    end

    assign grant0_cnt = r_cnt0;
    assign grant1_cnt = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A behavioural model of
//               the shared ALU drives the DUT ALU inputs. A scoreboard
//               predicts grants, responses and counters. Table vectors and
//               hand-written sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int TB_CNT_W = 4;
    localparam int c_CNT_MAX = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                reset;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [6:0]          req0_ctl, req1_ctl;
    logic [31:0]         req0_a, req0_b, req1_a, req1_b;
    logic                flush;
    logic [6:0]          alu_ctl;
    logic [31:0]         alu_a, alu_b, alu_out;
    logic                alu_branch_enable;
    logic                resp0_valid, resp1_valid;
    logic [31:0]         resp_out;
    logic                resp_branch;
    logic [TB_CNT_W-1:0] grant0_cnt, grant1_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Shared ALU reference: returns {branch_enable, result}
    function automatic logic [32:0] f_alu(input logic [6:0] ctl,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        br;
        case (ctl[3:0])
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = a >> b[4:0];
            4'b0100: r = a << b[4:0];
            4'b0101: r = $signed(a) >>> b[4:0];
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        case (ctl[6:4])
            3'b001:  br = (r == 32'd0);
            3'b010:  br = (r != 32'd0);
            3'b011:  br = ($signed(a) <  $signed(b));
            3'b100:  br = ($signed(a) >= $signed(b));
            3'b101:  br = (a <  b);
            3'b110:  br = (a >= b);
            default: br = 1'b0;
        endcase
        return {br, r};
    endfunction

    assign {alu_branch_enable, alu_out} = f_alu(alu_ctl, alu_a, alu_b);

    alu_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req0_ctl          (req0_ctl),
        .req0_a            (req0_a),
        .req0_b            (req0_b),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .req1_ctl          (req1_ctl),
        .req1_a            (req1_a),
        .req1_b            (req1_b),
        .flush             (flush),
        .alu_ctl           (alu_ctl),
        .alu_a             (alu_a),
        .alu_b             (alu_b),
        .alu_out           (alu_out),
        .alu_branch_enable (alu_branch_enable),
        .resp0_valid       (resp0_valid),
        .resp1_valid       (resp1_valid),
        .resp_out          (resp_out),
        .resp_branch       (resp_branch),
        .grant0_cnt        (grant0_cnt),
        .grant1_cnt        (grant1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        br;
        int          due;
    } sb_t;

    sb_t q[$];
    int  cyc    = 0;
    logic m_last = 1'b1;
    int  m_cnt0 = 0;
    int  m_cnt1 = 0;

    // {grant1, grant0}
    function automatic logic [1:0] f_grant(input logic v0, input logic v1,
                                           input logic last, input logic rs,
                                           input logic fl);
        if (rs || fl)    return 2'b00;
        if (v0 && v1)    return last ? 2'b01 : 2'b10;
        if (v0)          return 2'b01;
        if (v1)          return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge reset) begin
        q.delete();
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    end

    always @(posedge clk) begin
        logic [1:0]  g;
        logic [32:0] r;
        sb_t         e;
        cyc++;
        if (!reset) begin
            if (flush) begin
                while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
            end else begin
                g = f_grant(req0_valid, req1_valid, m_last, 1'b0, 1'b0);
                if (g != 2'b00) begin
                    e.id  = g[1];
                    r     = g[1] ? f_alu(req1_ctl, req1_a, req1_b) : f_alu(req0_ctl, req0_a, req0_b);
                    e.out = r[31:0];
                    e.br  = r[32];
                    e.due = cyc + 1;
                    q.push_back(e);
                    m_last = g[1];
                    if (g[0] && m_cnt0 < c_CNT_MAX) m_cnt0++;
                    if (g[1] && m_cnt1 < c_CNT_MAX) m_cnt1++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        sb_t        e;
        g = f_grant(req0_valid, req1_valid, m_last, reset, flush);
        chk("sb_ready", {30'd0, req1_ready, req0_ready}, {30'd0, g});
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("sb_resp_valid", {30'd0, resp1_valid, resp0_valid}, e.id ? 32'd2 : 32'd1);
            chk("sb_resp_out", resp_out, e.out);
            chk("sb_resp_branch", {31'd0, resp_branch}, {31'd0, e.br});
        end else begin
            chk("sb_resp_idle", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        end
        chk("sb_cnt0", {28'd0, grant0_cnt}, m_cnt0);
        chk("sb_cnt1", {28'd0, grant1_cnt}, m_cnt1);
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        id;
        logic [6:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_br;
    } vec_t;

    vec_t tbl[8];

    task automatic drive(input logic id, input logic v, input logic [6:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_ctl = ctl; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_ctl = ctl; req0_a = a; req0_b = b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 7'h16, 32'h0000000F, 32'h0000000F, 32'h00000000, 1'b1}; // BEQ taken
        tbl[1] = '{1'b1, 7'h26, 32'h0000000E, 32'h00000055, 32'hFFFFFFB9, 1'b1}; // BNE taken
        tbl[2] = '{1'b1, 7'h36, 32'd10000,    32'd111,      32'h000026A1, 1'b0}; // BLT not taken
        tbl[3] = '{1'b0, 7'h02, 32'd5,        32'd7,        32'd12,       1'b0}; // ADD
        tbl[4] = '{1'b0, 7'h46, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0}; // BGE signed
        tbl[5] = '{1'b1, 7'h56, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0}; // BLTU
        tbl[6] = '{1'b0, 7'h66, 32'h00000010, 32'd2,        32'h0000000E, 1'b1}; // BGEU
        tbl[7] = '{1'b1, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0}; // AND

        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 1'b1, 7'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b1, 7'd0, 32'd0, 32'd0);

        // Reset state, with both requesters asking
        @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_alu_ctl", {25'd0, alu_ctl}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_resp_out", resp_out, 32'd0);
        chk("rst_resp_branch", {31'd0, resp_branch}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;

        // Single operations from the table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].id, 1'b1, tbl[i].ctl, tbl[i].a, tbl[i].b);
            @(posedge clk); #1;
            drive(tbl[i].id, 1'b0, 7'd0, 32'd0, 32'd0);
            @(negedge clk);
            chk("tbl_alu_ctl", {25'd0, alu_ctl}, {25'd0, tbl[i].ctl});
            chk("tbl_alu_a", alu_a, tbl[i].a);
            chk("tbl_alu_b", alu_b, tbl[i].b);
            @(negedge clk);
            chk("tbl_resp_valid", {31'd0, tbl[i].id ? resp1_valid : resp0_valid}, 32'd1);
            chk("tbl_resp_other", {31'd0, tbl[i].id ? resp0_valid : resp1_valid}, 32'd0);
            chk("tbl_resp_out", resp_out, tbl[i].exp_out);
            chk("tbl_resp_branch", {31'd0, resp_branch}, {31'd0, tbl[i].exp_br});
        end

        // Contention after a reset pulse: grants 0,1,0,1
        @(posedge clk); #1 reset = 1'b1; #2 reset = 1'b0;
        drive(1'b0, 1'b1, 7'h16, 32'h0F, 32'h0F);
        drive(1'b1, 1'b1, 7'h26, 32'h0E, 32'h55);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready1", {31'd0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cont_cnt0", {28'd0, grant0_cnt}, 32'd2);
        chk("cont_cnt1", {28'd0, grant1_cnt}, 32'd2);

        // Back-to-back issue from requester 1
        @(posedge clk); #1 drive(1'b1, 1'b1, 7'h56, 32'd0, 32'd2);
        @(posedge clk); #1 drive(1'b1, 1'b1, 7'h66, 32'h10, 32'd2);
        @(posedge clk); #1 drive(1'b1, 1'b1, 7'h36, 32'd10000, 32'd111);
        @(negedge clk);
        chk("pipe_v0", {31'd0, resp1_valid}, 32'd1);
        chk("pipe_br0", {31'd0, resp_branch}, 32'd1);
        @(posedge clk); #1 drive(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("pipe_v1", {31'd0, resp1_valid}, 32'd1);
        chk("pipe_br1", {31'd0, resp_branch}, 32'd1);
        @(negedge clk);
        chk("pipe_v2", {31'd0, resp1_valid}, 32'd1);
        chk("pipe_br2", {31'd0, resp_branch}, 32'd0);
        @(negedge clk);
        chk("pipe_idle", {31'd0, resp1_valid}, 32'd0);
        chk("pipe_hold", resp_out, 32'h000026A1);

        // Flush right after a transfer
        @(posedge clk); #1 drive(1'b0, 1'b1, 7'h02, 32'd3, 32'd4);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_ready0", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_noresp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        end

        // Counter saturation
        @(posedge clk); #1 reset = 1'b1; #2 reset = 1'b0;
        drive(1'b0, 1'b1, 7'h02, 32'd1, 32'd1);
        repeat (20) @(posedge clk);
        #1 drive(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("sat_cnt0", {28'd0, grant0_cnt}, 32'd15);
        chk("sat_cnt1", {28'd0, grant1_cnt}, 32'd0);
        repeat (2) @(negedge clk);

        // Asynchronous reset with S1 and S2 both occupied
        @(posedge clk); #1 drive(1'b0, 1'b1, 7'h02, 32'd1, 32'd2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b1, 7'h06, 32'd9, 32'd4);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
        chk("ar_pre_resp0", {31'd0, resp0_valid}, 32'd1);
        chk("ar_pre_alu_ctl", {25'd0, alu_ctl}, 32'h06);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("ar_alu_ctl", {25'd0, alu_ctl}, 32'd0);
        chk("ar_alu_a", alu_a, 32'd0);
        chk("ar_alu_b", alu_b, 32'd0);
        chk("ar_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("ar_resp_out", resp_out, 32'd0);
        chk("ar_cnt0", {28'd0, grant0_cnt}, 32'd0);
        chk("ar_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_noresp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 7'h02, 32'd2, 32'd2);
        drive(1'b1, 1'b1, 7'h02, 32'd3, 32'd3);
        @(negedge clk);
        chk("ar_first_ready0", {31'd0, req0_ready}, 32'd1);
        chk("ar_first_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of each saturating grant counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester i has an ALU operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  grant; the operation transfers when valid & ready at a rising edge.
REQ-006 req0_ctl, req1_ctl  input  7 each  ALUctl code, [6:4] branch condition, [3:0] ALU op, per sail-core defines.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-008 flush  input  1  squash all in-flight operations.
REQ-009 alu_ctl  output  7; alu_a, alu_b  output  32  registered drive to the shared combinational ALU (ALUctl, A, B).
REQ-010 alu_out  input  32; alu_branch_enable  input  1  ALU result and Branch_Enable.
REQ-011 resp0_valid, resp1_valid  output  1 each  one-cycle result strobe to requester i.
REQ-012 resp_out  output  32; resp_branch  output  1  shared result and branch-taken flag, meaningful only while a resp*_valid is high.
REQ-013 grant0_cnt, grant1_cnt  output  CNT_W each  accepted-operation counters.

Function
REQ-014 Arbitration: combinational; at most one ready high per cycle; ready_i high only if valid_i high.
REQ-015 Single valid requester is granted immediately, regardless of priority state.
REQ-016 Both valid: grant goes to the requester not granted last; last_grant updates only on an actual transfer.
REQ-017 Requests need not be held after transfer; unaccepted requests may change or drop (no stickiness required).
REQ-018 Pipeline: stage S1 (issue regs) captures ctl/a/b plus requester id and s1_valid on transfer edge.
REQ-019 While s1_valid=0, alu_ctl, alu_a, alu_b drive 0.
REQ-020 Stage S2 captures alu_out, alu_branch_enable, id and valid from S1 on the next edge.
REQ-021 Latency: transfer at edge N -> resp{id}_valid high for exactly the cycle after edge N+1; the other resp*_valid low.
REQ-022 Throughput one operation per cycle; back-to-back transfers produce back-to-back responses in grant order.
REQ-023 No response backpressure; requesters must accept resp*_valid when it occurs.
REQ-024 flush high at an edge: s1_valid and s2_valid clear to 0; ready outputs forced low while flush is high (no transfer that cycle).
REQ-025 flush does not change last_grant or counters.
REQ-026 grant_i_cnt increments by 1 on each transfer from requester i; saturates at 2^CNT_W-1 (no wrap).
REQ-027 resp_out/resp_branch hold last captured value when no response is valid.

Reset
REQ-028 reset asserted: s1_valid=0, s2_valid=0, alu_ctl/a/b=0, resp_out=0, resp_branch=0, counters=0, last_grant=1 (requester 0 wins first contention), immediately without a clock edge.
REQ-029 Reset asserted mid-operation discards all in-flight operations; no response emitted for them after release.
REQ-030 ready outputs are low while reset is high.

Verification
REQ-031 Single op: req0 ctl[6:4]=BEQ, a=0x0F, b=0x0F, valid one cycle -> alu_ctl/a/b show it one cycle later; resp0_valid one cycle after that, resp_branch=1.
REQ-032 Contention: both valid continuously for 4 cycles (req1 BNE a=0x0E b=0x55) -> grants 0,1,0,1; resp strobes alternate 0,1,0,1 with resp_branch=1 on req1 responses; counters 2/2.
REQ-033 Pipelining: req1 only, BLTU a=0 b=2 then BGEU a=0x10 b=2 back-to-back -> two consecutive resp1_valid cycles, resp_branch 1 then 1; BLT a=10000 b=111 -> resp_branch 0.
REQ-034 Flush: transfer at edge N, flush high across edge N+1 -> no resp*_valid ever for it; ready low during flush cycle.
REQ-035 Saturation: CNT_W=4, 20 req0 transfers -> grant0_cnt stops at 15.
REQ-036 Async reset: assert reset between edges with S1 and S2 valid -> outputs zero immediately, no response after release, first contention grants req0.
